// File: rtl/wb_classic_arbiter_if.sv
// Flattened controller-side and device-side Wishbone classic signals seen by the arbiter.
// Slave modport is the arbiter's view; master is the environment's (controllers plus device).
interface wb_classic_arbiter_if #(
  parameter int N_CTRL    = 4,
  parameter int DAT_WIDTH = 8
);
  logic [N_CTRL-1:0]           c_cyc_i;
  logic [N_CTRL-1:0]           c_stb_i;
  logic [N_CTRL-1:0]           c_we_i;
  logic [N_CTRL*DAT_WIDTH-1:0] c_dat_i;
  logic [N_CTRL-1:0]           c_ack_o;
  logic [N_CTRL-1:0]           c_err_o;
  logic [N_CTRL-1:0]           c_rty_o;
  logic [DAT_WIDTH-1:0]        c_dat_o;
  logic                        d_cyc_o;
  logic                        d_stb_o;
  logic                        d_we_o;
  logic [DAT_WIDTH-1:0]        d_dat_o;
  logic                        d_ack_i;
  logic                        d_err_i;
  logic                        d_rty_i;
  logic [DAT_WIDTH-1:0]        d_dat_i;
  logic [N_CTRL-1:0]           grant_o;
  logic                        timeout_o;

  modport slave (
    input  c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_dat_i,
    output c_ack_o, c_err_o, c_rty_o, c_dat_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o,
           grant_o, timeout_o
  );

  modport master (
    output c_cyc_i, c_stb_i, c_we_i, c_dat_i, d_ack_i, d_err_i, d_rty_i, d_dat_i,
    input  c_ack_o, c_err_o, c_rty_o, c_dat_o, d_cyc_o, d_stb_o, d_we_o, d_dat_o,
           grant_o, timeout_o
  );
endinterface

// File: rtl/wb_classic_arbiter.sv
// Round-robin arbiter sharing one Wishbone classic device among N_CTRL controllers,
// with a watchdog that aborts unanswered requests with err after TIMEOUT cycles.
module wb_classic_arbiter #(
  parameter int N_CTRL    = 4,
  parameter int DAT_WIDTH = 8,
  parameter int TIMEOUT   = 16
) (
  input logic             clk_i,
  input logic             rst_ni,
  wb_classic_arbiter_if.slave bus
);
  localparam int IW = $clog2(N_CTRL);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam bit WD_EN = (TIMEOUT > 0);
  localparam logic [TW-1:0] TMAX = TW'(TIMEOUT);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] OWNED = 2'd1;
  localparam logic [1:0] ABORT = 2'd2;

  logic [1:0]        state_q;
  logic [N_CTRL-1:0] grant_q;
  logic [IW-1:0]     own_q;
  logic [IW-1:0]     last_q;
  logic [TW-1:0]     timer_q;

  logic [IW-1:0]     pick;
  logic [IW-1:0]     scan;
  logic              pick_vld;

  logic                 own_cyc;
  logic                 own_stb;
  logic                 own_we;
  logic [DAT_WIDTH-1:0] own_dat;
  logic                 owned;
  logic                 pending;
  logic                 abort;

  logic [N_CTRL-1:0]    ack_v;
  logic [N_CTRL-1:0]    err_v;
  logic [N_CTRL-1:0]    rty_v;
  logic                 d_cyc_v;
  logic                 d_stb_v;
  logic                 d_we_v;
  logic [DAT_WIDTH-1:0] d_dat_v;

  // Scan starts just past the previous owner so every requester is eventually served.
  always_comb begin
    pick     = '0;
    pick_vld = 1'b0;
    scan     = '0;
    for (int i = 1; i <= N_CTRL; i++) begin
      scan = IW'((int'(last_q) + i) % N_CTRL);
      if (!pick_vld && bus.c_cyc_i[scan]) begin
        pick_vld = 1'b1;
        pick     = scan;
      end
    end
  end

  assign own_cyc = bus.c_cyc_i[own_q];
  assign own_stb = bus.c_stb_i[own_q];
  assign own_we  = bus.c_we_i[own_q];
  assign own_dat = bus.c_dat_i[int'(own_q)*DAT_WIDTH +: DAT_WIDTH];

  assign owned   = (state_q == OWNED);
  assign pending = owned && own_cyc && own_stb && !(bus.d_ack_i || bus.d_err_i || bus.d_rty_i);
  // Abort overrides any device response landing in the same cycle.
  assign abort   = WD_EN && owned && own_cyc && (timer_q == TMAX);

  always_comb begin
    ack_v   = '0;
    err_v   = '0;
    rty_v   = '0;
    d_cyc_v = 1'b0;
    d_stb_v = 1'b0;
    d_we_v  = 1'b0;
    d_dat_v = '0;
    if (owned && !abort) begin
      d_cyc_v       = own_cyc;
      d_stb_v       = own_stb;
      d_we_v        = own_we;
      d_dat_v       = own_dat;
      ack_v[own_q]  = bus.d_ack_i;
      err_v[own_q]  = bus.d_err_i;
      rty_v[own_q]  = bus.d_rty_i;
    end
    if (abort) begin
      err_v[own_q] = 1'b1;
    end
  end

  assign bus.c_ack_o   = ack_v;
  assign bus.c_err_o   = err_v;
  assign bus.c_rty_o   = rty_v;
  assign bus.c_dat_o   = bus.d_dat_i;
  assign bus.d_cyc_o   = d_cyc_v;
  assign bus.d_stb_o   = d_stb_v;
  assign bus.d_we_o    = d_we_v;
  assign bus.d_dat_o   = d_dat_v;
  assign bus.grant_o   = grant_q;
  assign bus.timeout_o = abort;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      grant_q <= '0;
      own_q   <= '0;
      last_q  <= IW'(N_CTRL - 1);
      timer_q <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          timer_q <= '0;
          if (pick_vld) begin
            state_q <= OWNED;
            grant_q <= {{(N_CTRL-1){1'b0}}, 1'b1} << pick;
            own_q   <= pick;
          end
        end
        OWNED: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= own_q;
            timer_q <= '0;
          end else if (abort) begin
            state_q <= ABORT;
          end else if (WD_EN && pending) begin
            // Saturate so the counter can never wrap back to zero.
            timer_q <= (timer_q == TMAX) ? timer_q : timer_q + TW'(1);
          end else begin
            timer_q <= '0;
          end
        end
        ABORT: begin
          if (!own_cyc) begin
            state_q <= IDLE;
            grant_q <= '0;
            last_q  <= own_q;
            timer_q <= '0;
          end
        end
        default: begin
          state_q <= IDLE;
          grant_q <= '0;
          timer_q <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_wb_classic_arbiter.sv
// Directed bench: dut_a uses TIMEOUT=16, dut_b uses TIMEOUT=4 for the watchdog scenarios.
module tb_wb_classic_arbiter;
  logic clk;
  logic rst_a;
  logic rst_b;
  int   checks;
  int   errors;

  wb_classic_arbiter_if #(.N_CTRL(4), .DAT_WIDTH(8)) ia ();
  wb_classic_arbiter_if #(.N_CTRL(4), .DAT_WIDTH(8)) ib ();

  wb_classic_arbiter #(.N_CTRL(4), .DAT_WIDTH(8), .TIMEOUT(16)) dut_a (
    .clk_i (clk),
    .rst_ni(rst_a),
    .bus   (ia)
  );

  wb_classic_arbiter #(.N_CTRL(4), .DAT_WIDTH(8), .TIMEOUT(4)) dut_b (
    .clk_i (clk),
    .rst_ni(rst_b),
    .bus   (ib)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b0; rst_b = 1'b0;
    ia.c_cyc_i = '0; ia.c_stb_i = '0; ia.c_we_i = '0; ia.c_dat_i = '0;
    ia.d_ack_i = 1'b0; ia.d_err_i = 1'b0; ia.d_rty_i = 1'b0; ia.d_dat_i = '0;
    ib.c_cyc_i = '0; ib.c_stb_i = '0; ib.c_we_i = '0; ib.c_dat_i = '0;
    ib.d_ack_i = 1'b0; ib.d_err_i = 1'b0; ib.d_rty_i = 1'b0; ib.d_dat_i = '0;
    #12;
    checks++; if (ia.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant: got %b want 0000", ia.grant_o); end
    checks++; if ({ia.d_cyc_o, ia.d_stb_o, ia.d_we_o} !== 3'b000) begin errors++; $display("FAIL reset_dev: got %b want 000", {ia.d_cyc_o, ia.d_stb_o, ia.d_we_o}); end
    checks++; if ({ia.c_ack_o, ia.c_err_o, ia.c_rty_o, ia.timeout_o} !== 13'h0) begin errors++; $display("FAIL reset_resp: got %h want 0", {ia.c_ack_o, ia.c_err_o, ia.c_rty_o, ia.timeout_o}); end
    checks++; if (ib.grant_o !== 4'b0000) begin errors++; $display("FAIL reset_grant_b: got %b want 0000", ib.grant_o); end
    #10;
    rst_a = 1'b1; rst_b = 1'b1;
  endtask

  task automatic test_single_write;
    step;
    ia.c_cyc_i = 4'b0001; ia.c_stb_i = 4'b0001; ia.c_we_i = 4'b0001; ia.c_dat_i = 32'h0000_00A5;
    #1;
    checks++; if (ia.d_cyc_o !== 1'b0) begin errors++; $display("FAIL wr_c0_dcyc: got %b want 0", ia.d_cyc_o); end
    step;
    checks++; if (ia.grant_o !== 4'b0001) begin errors++; $display("FAIL wr_c1_grant: got %b want 0001", ia.grant_o); end
    checks++; if ({ia.d_cyc_o, ia.d_stb_o, ia.d_we_o} !== 3'b111) begin errors++; $display("FAIL wr_c1_dev: got %b want 111", {ia.d_cyc_o, ia.d_stb_o, ia.d_we_o}); end
    checks++; if (ia.d_dat_o !== 8'hA5) begin errors++; $display("FAIL wr_c1_dat: got %h want a5", ia.d_dat_o); end
    step;
    ia.d_ack_i = 1'b1;
    #1;
    checks++; if (ia.c_ack_o !== 4'b0001) begin errors++; $display("FAIL wr_c2_ack: got %b want 0001", ia.c_ack_o); end
    step;
    ia.d_ack_i = 1'b0; ia.c_cyc_i = '0; ia.c_stb_i = '0; ia.c_we_i = '0;
    #1;
    checks++; if (ia.d_cyc_o !== 1'b0) begin errors++; $display("FAIL wr_c3_dcyc: got %b want 0", ia.d_cyc_o); end
    step;
    checks++; if (ia.grant_o !== 4'b0000) begin errors++; $display("FAIL wr_c4_grant: got %b want 0000", ia.grant_o); end
  endtask

  task automatic test_read_rty;
    step;
    ia.c_cyc_i = 4'b0100; ia.c_stb_i = 4'b0100; ia.c_we_i = 4'b0000; ia.c_dat_i = '0;
    step;
    ia.d_rty_i = 1'b1;
    #1;
    checks++; if (ia.grant_o !== 4'b0100) begin errors++; $display("FAIL rd_grant: got %b want 0100", ia.grant_o); end
    checks++; if (ia.c_rty_o !== 4'b0100 || ia.c_ack_o !== 4'b0000) begin errors++; $display("FAIL rd_rty: got rty %b ack %b want 0100 0000", ia.c_rty_o, ia.c_ack_o); end
    step;
    ia.d_rty_i = 1'b0; ia.c_stb_i = 4'b0000;
    step;
    ia.c_stb_i = 4'b0100; ia.d_ack_i = 1'b1; ia.d_dat_i = 8'h3C;
    #1;
    checks++; if (ia.c_ack_o !== 4'b0100 || ia.c_rty_o !== 4'b0000 || ia.c_err_o !== 4'b0000) begin errors++; $display("FAIL rd_ack: got ack %b rty %b err %b want 0100 0000 0000", ia.c_ack_o, ia.c_rty_o, ia.c_err_o); end
    checks++; if (ia.c_dat_o !== 8'h3C) begin errors++; $display("FAIL rd_dat: got %h want 3c", ia.c_dat_o); end
    step;
    ia.d_ack_i = 1'b0; ia.d_dat_i = '0; ia.c_cyc_i = '0; ia.c_stb_i = '0;
    step;
    checks++; if (ia.grant_o !== 4'b0000) begin errors++; $display("FAIL rd_release: got %b want 0000", ia.grant_o); end
  endtask

  task automatic test_round_robin;
    logic [3:0] exp_g;
    #3 rst_a = 1'b0;
    #2 rst_a = 1'b1;
    step;
    ia.c_cyc_i = 4'b1111; ia.c_stb_i = 4'b0000;
    for (int k = 0; k < 5; k++) begin
      exp_g = 4'b0001 << (k % 4);
      step;
      checks++; if (ia.grant_o !== exp_g || ia.d_cyc_o !== 1'b1) begin errors++; $display("FAIL rr_grant%0d: got %b cyc %b want %b cyc 1", k, ia.grant_o, ia.d_cyc_o, exp_g); end
      step;
      step;
      ia.c_cyc_i = 4'b1111 & ~exp_g;
      #1;
      checks++; if (ia.d_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_drop%0d: got %b want 0", k, ia.d_cyc_o); end
      step;
      ia.c_cyc_i = 4'b1111;
      #1;
      checks++; if (ia.grant_o !== 4'b0000 || ia.d_cyc_o !== 1'b0) begin errors++; $display("FAIL rr_gap%0d: got %b cyc %b want 0000 cyc 0", k, ia.grant_o, ia.d_cyc_o); end
    end
    ia.c_cyc_i = 4'b0000;
    step;
    step;
  endtask

  task automatic test_timeout;
    step;
    ib.c_cyc_i = 4'b0010; ib.c_stb_i = 4'b0010;
    step;
    checks++; if (ib.d_cyc_o !== 1'b1 || ib.grant_o !== 4'b0010) begin errors++; $display("FAIL to_t0: got cyc %b grant %b want 1 0010", ib.d_cyc_o, ib.grant_o); end
    for (int k = 1; k < 4; k++) begin
      step;
      checks++; if (ib.c_err_o !== 4'b0000 || ib.timeout_o !== 1'b0 || ib.d_cyc_o !== 1'b1) begin errors++; $display("FAIL to_wait%0d: got err %b to %b cyc %b want 0000 0 1", k, ib.c_err_o, ib.timeout_o, ib.d_cyc_o); end
    end
    step;
    checks++; if (ib.c_err_o !== 4'b0010 || ib.timeout_o !== 1'b1) begin errors++; $display("FAIL to_abort: got err %b to %b want 0010 1", ib.c_err_o, ib.timeout_o); end
    checks++; if (ib.d_cyc_o !== 1'b0 || ib.d_stb_o !== 1'b0) begin errors++; $display("FAIL to_abort_dev: got cyc %b stb %b want 0 0", ib.d_cyc_o, ib.d_stb_o); end
    step;
    ib.d_ack_i = 1'b1;
    #1;
    checks++; if (ib.c_ack_o !== 4'b0000 || ib.c_err_o !== 4'b0000 || ib.timeout_o !== 1'b0 || ib.d_cyc_o !== 1'b0) begin errors++; $display("FAIL to_late_ack: got ack %b err %b to %b cyc %b want 0000 0000 0 0", ib.c_ack_o, ib.c_err_o, ib.timeout_o, ib.d_cyc_o); end
    step;
    ib.d_ack_i = 1'b0; ib.c_cyc_i = 4'b0000; ib.c_stb_i = 4'b0000;
    step;
    checks++; if (ib.grant_o !== 4'b0000) begin errors++; $display("FAIL to_idle: got %b want 0000", ib.grant_o); end
  endtask

  task automatic test_simultaneous;
    step;
    ib.c_cyc_i = 4'b1000; ib.c_stb_i = 4'b1000;
    step;
    checks++; if (ib.grant_o !== 4'b1000) begin errors++; $display("FAIL sim_grant: got %b want 1000", ib.grant_o); end
    for (int k = 1; k < 4; k++) step;
    step;
    ib.d_ack_i = 1'b1;
    #1;
    checks++; if (ib.c_err_o !== 4'b1000 || ib.c_ack_o !== 4'b0000 || ib.timeout_o !== 1'b1) begin errors++; $display("FAIL sim_abort: got err %b ack %b to %b want 1000 0000 1", ib.c_err_o, ib.c_ack_o, ib.timeout_o); end
    step;
    ib.d_ack_i = 1'b0; ib.c_cyc_i = 4'b0000; ib.c_stb_i = 4'b0000;
    step;
    step;
  endtask

  task automatic test_async_reset;
    step;
    ia.c_cyc_i = 4'b0100; ia.c_stb_i = 4'b0100;
    step;
    ia.d_ack_i = 1'b1;
    #1;
    checks++; if (ia.grant_o !== 4'b0100 || ia.d_cyc_o !== 1'b1 || ia.c_ack_o !== 4'b0100) begin errors++; $display("FAIL ar_pre: got grant %b cyc %b ack %b want 0100 1 0100", ia.grant_o, ia.d_cyc_o, ia.c_ack_o); end
    #1 rst_a = 1'b0;
    #1;
    checks++; if (ia.grant_o !== 4'b0000 || ia.d_cyc_o !== 1'b0 || ia.c_ack_o !== 4'b0000) begin errors++; $display("FAIL ar_clear: got grant %b cyc %b ack %b want 0000 0 0000", ia.grant_o, ia.d_cyc_o, ia.c_ack_o); end
    ia.d_ack_i = 1'b0;
    ia.c_cyc_i = 4'b0101; ia.c_stb_i = 4'b0101;
    #2 rst_a = 1'b1;
    step;
    checks++; if (ia.grant_o !== 4'b0001) begin errors++; $display("FAIL ar_first: got %b want 0001", ia.grant_o); end
    ia.c_cyc_i = 4'b0000; ia.c_stb_i = 4'b0000;
    step;
    step;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    test_reset;
    test_single_write;
    test_read_rty;
    test_round_robin;
    test_timeout;
    test_simultaneous;
    test_async_reset;
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/wb_classic_arbiter.md
Name: wb_classic_arbiter

Overview:
- Round-robin arbiter that shares one Wishbone B4 classic device among N_CTRL controllers, using the same signal set as the wishbone_classic interface.
- Signals: cyc, stb, we, dat (controller side) and ack, err, rty, dat (device side).
- Includes a bus watchdog that aborts stalled requests with err, so a silent device cannot lock the bus.
- Sits between controller-side and device-side wishbone_classic instances; ports are flattened vectors.

Parameters:
- N_CTRL, 4, number of controllers (2..16).
- DAT_WIDTH, 8, data width, matches the interface parameter.
- TIMEOUT, 16, cycles an unanswered request may stay pending before abort; 0 disables the watchdog.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  asynchronous active-low reset.
- c_cyc_i  in  N_CTRL  controller cyc, bit k = controller k.
- c_stb_i  in  N_CTRL  controller stb.
- c_we_i  in  N_CTRL  controller we.
- c_dat_i  in  N_CTRL*DAT_WIDTH  controller write data; slice k = controller k.
- c_ack_o  out  N_CTRL  ack to controllers.
- c_err_o  out  N_CTRL  err to controllers.
- c_rty_o  out  N_CTRL  rty to controllers.
- c_dat_o  out  DAT_WIDTH  read data, broadcast to all controllers.
- d_cyc_o  out  1  device cyc.
- d_stb_o  out  1  device stb.
- d_we_o  out  1  device we.
- d_dat_o  out  DAT_WIDTH  device write data.
- d_ack_i  in  1  device ack.
- d_err_i  in  1  device err.
- d_rty_i  in  1  device rty.
- d_dat_i  in  DAT_WIDTH  device read data.
- grant_o  out  N_CTRL  registered one-hot owner; 0 when no owner.
- timeout_o  out  1  one-cycle pulse when the watchdog aborts.

Behaviour:
- Reset (async, rst_ni=0):
  - state=IDLE, grant_o=0, last-owner pointer=N_CTRL-1 (controller 0 has first priority), watchdog timer=0.
  - All d_* and c_*_o outputs and timeout_o = 0.
- States: IDLE, OWNED, ABORT.
- IDLE:
  - Device outputs d_cyc_o/d_stb_o/d_we_o = 0, d_dat_o = 0.
  - c_ack_o/c_err_o/c_rty_o = 0; device responses are ignored.
  - If any c_cyc_i is set, select the first set bit scanning from (last+1) mod N_CTRL upward with wrap.
  - Register the selection in grant_o and move to OWNED on the next edge. Arbitration latency is 1 cycle.
- OWNED (owner g):
  - d_cyc_o, d_stb_o, d_we_o and d_dat_o follow controller g combinationally.
  - d_ack_i, d_err_i and d_rty_i are routed combinationally to bit g only; all other bits stay 0.
  - c_dat_o = d_dat_i at all times, in every state.
  - The owner keeps the bus across multiple stb transfers while c_cyc_i[g] stays high.
  - When c_cyc_i[g]=0: d_cyc_o falls in the same cycle; next state IDLE, last=g, grant_o=0.
  - This guarantees at least one cycle of d_cyc_o=0 between consecutive owners.
- Watchdog (TIMEOUT>0, OWNED only):
  - Pending = d_cyc_o && d_stb_o && !(d_ack_i||d_err_i||d_rty_i). The timer increments each pending cycle and clears otherwise.
  - When timer==TIMEOUT:
    - c_err_o[g]=1, timeout_o=1.
    - d_cyc_o=d_stb_o=0 in that cycle.
    - Device responses arriving in that cycle are discarded; the abort wins.
    - Next state ABORT.
  - Timer width is clog2(TIMEOUT+1). The timer must never wrap.
- ABORT:
  - Device outputs held 0; device responses ignored; no c_*_o responses.
  - When c_cyc_i[g]=0: next state IDLE, last=g, timer=0.
- Non-owner requests are never dropped: they wait in IDLE arbitration; no response is produced to non-owners.
- Owner raising stb without cyc: passes through to d_stb_o, but d_cyc_o=0 makes it a non-request and the timer does not count.
- Reset asserted mid-cycle: outputs clear immediately (async); the device sees cyc drop and no response is delivered.

Test Plan:
1. Single write (TIMEOUT=16):
   - Stimulus: cycle 0 sets c_cyc/stb/we[0]=1, c_dat slice0=0xA5; cycle 2 d_ack_i=1; cycle 3 c_cyc_i[0]=0.
   - Required: cycle 1 grant_o=0001, d_cyc/stb/we=1, d_dat_o=0xA5; cycle 2 c_ack_o=0001; cycle 3 d_cyc_o=0; cycle 4 grant_o=0.
2. Read with rty:
   - Stimulus: controller 2 reads; device gives d_rty_i=1, then next request d_ack_i=1 with d_dat_i=0x3C.
   - Required: c_rty_o=0100, then c_ack_o=0100; c_dat_o=0x3C.
3. Round robin:
   - Stimulus: all four c_cyc_i held high; each owner drops cyc 2 cycles after grant, then re-asserts.
   - Required: grant order 0,1,2,3,0; exactly one grant_o=0 cycle between owners.
4. Timeout (TIMEOUT=4):
   - Stimulus: controller 1 requests; device silent.
   - Required: request first on device at cycle t; at t+4 c_err_o=0010, timeout_o=1, d_cyc_o=0; d_ack_i at t+5 gives no c_ack_o; IDLE one cycle after c_cyc_i[1] falls.
5. Simultaneous events:
   - Stimulus: d_ack_i asserted in the same cycle the timer reaches TIMEOUT.
   - Required: only err delivered; c_ack_o stays 0.
6. Async reset:
   - Stimulus: rst_ni=0 mid-OWNED between clock edges.
   - Required: d_cyc_o, grant_o and c_*_o go to 0 immediately; after release, controller 0 wins the first arbitration.
